// File: rtl/bec_wb_loader_pkg.sv
// Shared constants for the BEC Wishbone loader: widths, register map, slot ids and FSM states.
package bec_pkg;

  localparam int BEC_DATA_W = 163;
  localparam int BEC_NWORDS = (BEC_DATA_W + 31) / 32;

  // Byte offsets within the 256-byte window
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_OP0  = 8'h10;
  localparam logic [7:0] OFF_RES0 = 8'h30;

  // Same offsets as word indices (offset[7:2])
  localparam logic [5:0] WIDX_CTRL = 6'd0;
  localparam logic [5:0] WIDX_STAT = 6'd1;
  localparam logic [5:0] WIDX_OP0  = 6'd4;
  localparam logic [5:0] WIDX_RES0 = 6'd12;

  localparam logic [2:0] SLOT_X   = 3'd0;
  localparam logic [2:0] SLOT_Y   = 3'd1;
  localparam logic [2:0] SLOT_D   = 3'd2;
  localparam logic [2:0] SLOT_W   = 3'd3;
  localparam logic [2:0] SLOT_KEY = 3'd4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_CAPT = 2'd3;

endpackage

// File: rtl/bec_wb_loader_if.sv
// Wishbone slave bus bundle for the BEC loader.
// Handshake: a transfer is requested while stb&cyc are high; the slave raises ack for
// exactly one cycle, one cycle after the request, and read data is valid with that ack.
interface bec_wb_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/bec_wb_loader_regs.sv
// Bus decode, ack generation and the OP/RES word buffers of the BEC loader.
// Writes take effect in the ack cycle, using the request captured when ack was raised.
module bec_wb_regs
  import bec_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATA_W    = BEC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  bec_wb_loader_if.slave    wb,
  input  logic              busy_i,
  input  logic [31:0]       stat_i,
  input  logic              res_we_i,
  input  logic [DATA_W-1:0] res_i,
  output logic [DATA_W-1:0] op_o,
  output logic              ctrl_wr_o,
  output logic [31:0]       ctrl_dat_o,
  output logic [3:0]        ctrl_sel_o,
  output logic              op_rej_o
);

  localparam int NW = (DATA_W + 31) / 32;

  logic              ack_q, ack_d;
  logic [31:0]       dat_o_q, dat_o_d;
  logic              wr_q, wr_d;
  logic [5:0]        widx_q, widx_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        wsel_q, wsel_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic              hit;
  logic [5:0]        ridx;
  logic [NW*32-1:0]  op_pad, res_pad, op_pad_d;
  logic              unused_bits;

  assign unused_bits = ^{op_pad_d[NW*32-1:DATA_W], wb.wbs_adr_i[1:0]};

  always_comb begin
    hit    = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // The ~ack_q term forces one idle cycle between back-to-back acks
    ack_d  = hit & ~ack_q;
    wr_d   = ack_d & wb.wbs_we_i;
    widx_d = wb.wbs_adr_i[7:2];
    wdat_d = wb.wbs_dat_i;
    wsel_d = wb.wbs_sel_i;
    ridx   = wb.wbs_adr_i[7:2];

    op_pad  = '0;
    res_pad = '0;
    op_pad[DATA_W-1:0]  = op_q;
    res_pad[DATA_W-1:0] = res_q;

    dat_o_d = '0;
    if (ack_d && !wb.wbs_we_i) begin
      if (ridx == WIDX_STAT) dat_o_d = stat_i;
      for (int k = 0; k < NW; k++) begin
        if (ridx == 6'(WIDX_OP0 + k))  dat_o_d = op_pad[k*32 +: 32];
        if (ridx == 6'(WIDX_RES0 + k)) dat_o_d = res_pad[k*32 +: 32];
      end
    end

    op_pad_d  = op_pad;
    op_rej_o  = 1'b0;
    ctrl_wr_o = wr_q && (widx_q == WIDX_CTRL);
    for (int k = 0; k < NW; k++) begin
      if (wr_q && (widx_q == 6'(WIDX_OP0 + k))) begin
        if (busy_i) begin
          op_rej_o = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (wsel_q[b]) op_pad_d[k*32 + b*8 +: 8] = wdat_q[b*8 +: 8];
          end
        end
      end
    end
    // Bits above DATA_W in the last word are never stored, so they read back as 0
    op_d  = op_pad_d[DATA_W-1:0];
    res_d = res_we_i ? res_i : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      wr_q    <= 1'b0;
      widx_q  <= '0;
      wdat_q  <= '0;
      wsel_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      wr_q    <= wr_d;
      widx_q  <= widx_d;
      wdat_q  <= wdat_d;
      wsel_q  <= wsel_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;
  assign op_o         = op_q;
  assign ctrl_dat_o   = wdat_q;
  assign ctrl_sel_o   = wsel_q;

endmodule

// File: rtl/bec_wb_loader.sv
// Wishbone front end for the BEC core: operand load sequencing, run control with timeout,
// result capture and done interrupt.
module bec_wb_loader
  import bec_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATA_W    = BEC_DATA_W,
  parameter int          TMO_W     = 24
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  bec_wb_loader_if.slave    wb,
  output logic [DATA_W-1:0] core_data_o,
  output logic [2:0]        core_slot_o,
  output logic              core_load_o,
  output logic              core_ena_o,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_res_i,
  input  logic [3:0]        core_stat_i,
  output logic              irq_o
);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             rej_q, rej_d;
  logic             irq_en_q, irq_en_d;
  logic [2:0]       slot_q, slot_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic             busy, res_we;
  logic             ctrl_wr, op_rej;
  logic [31:0]      ctrl_dat, stat_word;
  logic [3:0]       ctrl_sel;
  logic             load_req, start_req, clear_req;
  logic             unused_ctrl;

  assign busy        = (state_q != ST_IDLE);
  assign stat_word   = {21'd0, 1'b0, state_q, core_stat_i, rej_q, tmo_q, done_q, busy};
  assign unused_ctrl = ^{ctrl_dat[31:9], ctrl_dat[7], ctrl_dat[3], ctrl_sel[3:2]};

  bec_wb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .DATA_W    (DATA_W)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .wb         (wb),
    .busy_i     (busy),
    .stat_i     (stat_word),
    .res_we_i   (res_we),
    .res_i      (core_res_i),
    .op_o       (core_data_o),
    .ctrl_wr_o  (ctrl_wr),
    .ctrl_dat_o (ctrl_dat),
    .ctrl_sel_o (ctrl_sel),
    .op_rej_o   (op_rej)
  );

  always_comb begin
    load_req  = ctrl_wr & ctrl_sel[0] & ctrl_dat[0];
    start_req = ctrl_wr & ctrl_sel[0] & ctrl_dat[1];
    clear_req = ctrl_wr & ctrl_sel[0] & ctrl_dat[2];

    state_d  = state_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    rej_d    = rej_q;
    irq_en_d = irq_en_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    res_we   = 1'b0;

    if (ctrl_wr && ctrl_sel[1]) irq_en_d = ctrl_dat[8];

    if (clear_req) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      rej_d   = 1'b0;
    end else begin
      if (op_rej) rej_d = 1'b1;
      if (busy && (load_req || start_req)) rej_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            state_d = ST_LOAD;
            slot_d  = ctrl_dat[6:4];
            if (start_req) rej_d = 1'b1;
          end else if (start_req) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        ST_LOAD: state_d = ST_IDLE;
        ST_RUN: begin
          if (core_done_i) begin
            state_d = ST_CAPT;
          end else begin
            cnt_d = cnt_q + TMO_W'(1);
            if (&cnt_d) begin
              tmo_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_CAPT: begin
          res_we  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      rej_q    <= 1'b0;
      irq_en_q <= 1'b0;
      slot_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      rej_q    <= rej_d;
      irq_en_q <= irq_en_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
    end
  end

  assign core_load_o = (state_q == ST_LOAD);
  assign core_ena_o  = (state_q == ST_RUN);
  assign core_slot_o = slot_q;
  assign irq_o       = done_q & irq_en_q;

endmodule
